// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: fetches at pc, holds the
// instruction for the datapath, then advances along sequential/branch/jump/jr paths.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] CODE_NONE      = 2'b00;
  localparam logic [1:0] CODE_MISALIGN  = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT   = 2'b10;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               req_q, req_d;
  logic               fault_q, fault_d;
  logic [1:0]         code_q, code_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [31:0]        pc_plus4_c;
  logic [31:0]        br_off_c;
  logic [31:0]        target_c;

  assign pc_plus4_c = pc_q + 32'd4;
  assign br_off_c   = {{14{branch_imm[15]}}, branch_imm, 2'b00};

  // Next-PC selection; priority jr > j > branch > sequential
  always_comb begin
    target_c = pc_plus4_c;
    if (jump_reg) begin
      target_c = reg_target;
    end else if (jump) begin
      target_c = {pc_plus4_c[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      target_c = pc_plus4_c + br_off_c;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    code_d  = code_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = S_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          fault_d = 1'b1;
          code_d  = CODE_TIMEOUT;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EXEC: begin
        if (!stall) begin
          valid_d = 1'b0;
          if (target_c[1:0] != 2'b00) begin
            fault_d = 1'b1;
            code_d  = CODE_MISALIGN;
            state_d = S_FAULT;
          end else begin
            pc_d    = target_c;
            state_d = S_FETCH;
          end
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase

    // Request is registered alongside the state it belongs to
    req_d = (state_d == S_FETCH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b1;
      fault_q <= 1'b0;
      code_q  <= CODE_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_c;
  assign fault       = fault_q;
  assign fault_code  = code_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Sequential program-counter and instruction-fetch sequencer for the MIPS datapath.
- Owns the PC register and computes the next PC: PC+4, branch target (PC+4 + sext(imm)<<2), jump target, or register target.
- Issues fetch requests to instruction memory with a req/ready handshake.
- Consumes the branch/jump decisions that the combinational datapath produces.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- TIMEOUT, 16, max cycles to wait for imem_ready before a fetch fault; range 2..255.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold the current PC and instruction; no new fetch
- branch_taken  in  1  take the branch target this update
- branch_imm  in  16  signed word offset from the instruction's imm field
- jump  in  1  take the J-type target this update
- jump_index  in  26  J-type index field
- jump_reg  in  1  take reg_target (jr) this update
- reg_target  in  32  register value for jr
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (always equals pc)
- imem_ready  in  1  memory accepts the request and returns data this cycle
- imem_rdata  in  32  instruction word, valid when imem_req && imem_ready
- instr  out  32  registered current instruction
- instr_valid  out  1  instr holds a fetched, unconsumed instruction
- pc  out  32  address of the instruction being fetched or held
- pc_plus4  out  32  pc + 4, combinational
- fault  out  1  sticky fault flag
- fault_code  out  2  00 none, 01 misaligned target, 10 fetch timeout

Behaviour:
- Reset (synchronous, checked first, overrides everything):
  - pc=RESET_PC, state=FETCH, instr=0, instr_valid=0, fault=0, fault_code=00, timeout counter=0.
  - A reset asserted mid-fetch drops the outstanding request with no memory side effects required.
- States: FETCH, EXEC, FAULT.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Each cycle without imem_ready increments the counter.
  - On imem_ready: instr<=imem_rdata, instr_valid<=1, counter<=0, go to EXEC. Latency is 1 cycle minimum from entering FETCH to instr_valid.
  - If the counter reaches TIMEOUT-1 and imem_ready is still 0: fault<=1, fault_code<=10, go to FAULT.
  - stall is ignored in FETCH.
- EXEC:
  - imem_req=0. The instruction is held while stall=1, with pc and instr unchanged.
  - First cycle with stall=0 computes next PC, priority highest first:
    - jump_reg: reg_target
    - jump: {pc_plus4[31:28], jump_index, 2'b00}
    - branch_taken: pc_plus4 + ({{14{imm[15]}}, imm, 2'b00}), 32-bit wrap
    - otherwise: pc_plus4
  - Simultaneous control inputs resolve by that priority only.
  - If next PC bits[1:0] != 0: pc unchanged, fault<=1, fault_code<=01, go to FAULT.
  - Otherwise: pc<=next, instr_valid<=0, go to FETCH.
- FAULT:
  - imem_req=0, instr_valid=0, all registers frozen; exit only by reset.
- Arithmetic: all adds are modulo 2^32.
  - pc=32'hFFFF_FFFC, sequential gives 0.
  - Branch offsets of -32768 and +32767 words must be exact.
- Every output except pc_plus4 and imem_addr is a register.
- pc_plus4 is valid in every state.

Test Plan:
- Reset with RESET_PC=0, imem_ready=1 constant, no control inputs -> pc 0,4,8,C on successive EXEC entries; instr_valid 1 cycle after each FETCH entry.
- pc=0x100, branch_taken=1, imm=16'hFFFE -> next pc=0x0FC; imm=16'h7FFF -> next pc=0x2_0100.
- pc=0x4000_0010, jump=1, jump_index=26'h000_0040 -> pc=0x4000_0100; jump_reg=1 and jump=1 together with reg_target=0x80 -> pc=0x80.
- jump_reg=1, reg_target=0x102 -> fault=1, fault_code=01, pc stays; imem_req remains 0 until reset.
- imem_ready held 0 with TIMEOUT=16 -> fault_code=10 exactly 16 cycles after entering FETCH; a ready on cycle 15 instead -> no fault.
- stall=1 for 5 cycles in EXEC, then a reset pulse during a later FETCH -> pc/instr held during stall; after reset pc=RESET_PC, instr_valid=0, fault=0.
